// File: rtl/microwave_timer_ctrl_pkg.sv
// rtl/microwave_timer_ctrl_pkg.sv - shared state encoding and BCD limits for the microwave timer controller
package microwave_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // A time is loadable when it is non-zero and its seconds-tens digit fits a mod-6 counter.
  function automatic logic entry_loadable(input logic [15:0] e);
    return (e != 16'h0000) && (e[7:4] <= SEC_TENS_MAX);
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_tick_prescaler.sv
// rtl/microwave_timer_ctrl_tick_prescaler.sv - divides clk down to a one-second tick, holding its phase when stopped
module microwave_timer_ctrl_tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - keypad entry, run/pause/done sequencing and second pacing for the MM:SS countdown chain
module microwave_timer_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BEEP_SECS = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_digit,
  input  logic        i_start,
  input  logic        i_stop_clr,
  input  logic        i_door_closed,
  input  logic        i_chain_zero,
  output logic        o_load_n,
  output logic        o_cnt_en,
  output logic [15:0] o_entry,
  output logic        o_mag_on,
  output logic        o_beep,
  output logic        o_entry_err,
  output logic [2:0]  o_state
);

  import microwave_timer_ctrl_pkg::*;

  localparam int            BW        = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

  state_t        r_state;
  logic [15:0]   r_entry;
  logic          r_load_n;
  logic          r_cnt_en;
  logic          r_mag_on;
  logic          r_beep;
  logic          r_entry_err;
  logic          r_first;
  logic [BW-1:0] r_beep_cnt;

  state_t        w_state_nxt;
  logic [15:0]   w_entry_nxt;
  logic          w_load;
  logic          w_err;
  logic          w_cnt;
  logic          w_clr;
  logic          w_first_nxt;
  logic [BW-1:0] w_beep_cnt_nxt;
  logic          w_run;
  logic          w_tick;
  logic          w_key_ok;
  logic          w_door_open;

  assign w_key_ok    = i_key_valid && (i_key_digit <= DIGIT_MAX);
  assign w_door_open = !i_door_closed;
  assign w_run       = (r_state == ST_RUN) || (r_state == ST_DONE);

  microwave_timer_ctrl_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .clrn   (clrn),
    .i_run  (w_run),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_entry_nxt    = r_entry;
    w_load         = 1'b0;
    w_err          = 1'b0;
    w_cnt          = 1'b0;
    w_clr          = 1'b0;
    w_first_nxt    = 1'b0;
    w_beep_cnt_nxt = r_beep_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_door_open && !i_stop_clr && w_key_ok) begin
          w_entry_nxt = {r_entry[11:0], i_key_digit};
          w_state_nxt = ST_SET;
        end
      end
      ST_SET: begin
        if (i_stop_clr && !w_door_open) begin
          w_entry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (i_start) begin
          if (!w_door_open && entry_loadable(r_entry)) begin
            w_load      = 1'b1;
            w_clr       = 1'b1;
            w_first_nxt = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_key_ok) begin
          w_entry_nxt = {r_entry[11:0], i_key_digit};
        end
      end
      ST_RUN: begin
        // chain_zero is stale until the load pulse has been taken by the chain
        if (w_tick && !r_first && !i_chain_zero) begin
          w_cnt = 1'b1;
        end
        if (w_door_open || i_stop_clr) begin
          w_state_nxt = ST_PAUSE;
        end else if (!r_first && i_chain_zero) begin
          w_clr          = 1'b1;
          w_beep_cnt_nxt = '0;
          w_state_nxt    = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (!w_door_open && i_stop_clr) begin
          w_entry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (!w_door_open && i_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!w_door_open && i_stop_clr) begin
          w_entry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_beep_cnt == BEEP_LAST) begin
            w_entry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_beep_cnt_nxt = r_beep_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_entry_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= ST_IDLE;
      r_entry     <= '0;
      r_load_n    <= 1'b1;
      r_cnt_en    <= 1'b0;
      r_mag_on    <= 1'b0;
      r_beep      <= 1'b0;
      r_entry_err <= 1'b0;
      r_first     <= 1'b0;
      r_beep_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_entry     <= w_entry_nxt;
      r_load_n    <= !w_load;
      r_cnt_en    <= w_cnt;
      r_mag_on    <= (w_state_nxt == ST_RUN);
      r_beep      <= (w_state_nxt == ST_DONE);
      r_entry_err <= w_err;
      r_first     <= w_first_nxt;
      r_beep_cnt  <= w_beep_cnt_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_entry     = r_entry;
  assign o_load_n    = r_load_n;
  assign o_cnt_en    = r_cnt_en;
  assign o_mag_on    = r_mag_on;
  assign o_beep      = r_beep;
  assign o_entry_err = r_entry_err;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb/tb_microwave_timer_ctrl.sv - scoreboard bench with a seconds-level cooking model and a behavioural countdown chain
module tb_microwave_timer_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int BEEP_SECS = 2;
  localparam int S_IDLE = 0, S_SET = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop_clr = 1'b0;
  logic        door_closed = 1'b1;
  logic        chain_zero = 1'b1;
  logic        load_n, cnt_en, mag_on, beep, entry_err;
  logic [15:0] entry;
  logic [2:0]  state;

  always #5 clk = ~clk;

  microwave_timer_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .BEEP_SECS (BEEP_SECS)
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .i_key_valid   (key_valid),
    .i_key_digit   (key_digit),
    .i_start       (start),
    .i_stop_clr    (stop_clr),
    .i_door_closed (door_closed),
    .i_chain_zero  (chain_zero),
    .o_load_n      (load_n),
    .o_cnt_en      (cnt_en),
    .o_entry       (entry),
    .o_mag_on      (mag_on),
    .o_beep        (beep),
    .o_entry_err   (entry_err),
    .o_state       (state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] entry;
    logic        load_n;
    logic        cnt_en;
    logic        mag_on;
    logic        beep;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;

  // Model: keypad digits as a list, seconds-within-tick phase, chain as plain seconds.
  int m_state, m_phase, m_beeps, m_chain;
  bit m_fresh, force_zero;
  int m_digits[$];

  task automatic chk(string name, int unsigned act, int unsigned expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  function automatic int unsigned entry_val();
    int unsigned v = 0;
    foreach (m_digits[i]) v = (v << 4) | m_digits[i];
    return v & 32'hFFFF;
  endfunction

  function automatic int entry_secs(int unsigned e);
    return ((e >> 12) & 15) * 600 + ((e >> 8) & 15) * 60 + ((e >> 4) & 15) * 10 + (e & 15);
  endfunction

  function automatic void add_digit(int d);
    m_digits.push_back(d);
    if (m_digits.size() > 4) void'(m_digits.pop_front());
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_digits.delete();
    m_phase = 0;
    m_beeps = 0;
    m_fresh = 0;
    cur.st = 3'd0; cur.entry = 16'h0; cur.load_n = 1'b1; cur.cnt_en = 1'b0;
    cur.mag_on = 1'b0; cur.beep = 1'b0; cur.err = 1'b0;
  endtask

  task automatic model_step();
    bit key_ok, tick, load, cnt, err;
    int ns;
    if (!cur.load_n) m_chain = entry_secs(cur.entry);
    else if (cur.cnt_en && m_chain > 0) m_chain--;
    key_ok = key_valid && (key_digit <= 4'd9);
    load = 0; cnt = 0; err = 0; tick = 0;
    ns = m_state;
    case (m_state)
      S_IDLE: if (door_closed && !stop_clr && key_ok) begin add_digit(int'(key_digit)); ns = S_SET; end
      S_SET: begin
        if (stop_clr && door_closed) begin m_digits.delete(); ns = S_IDLE; end
        else if (start) begin
          if (door_closed && entry_val() != 0 && ((entry_val() >> 4) & 15) <= 5) begin
            load = 1; m_phase = 0; m_fresh = 1; ns = S_RUN;
          end else err = 1;
        end else if (key_ok) add_digit(int'(key_digit));
      end
      S_RUN: begin
        tick = (m_phase == TICK_DIV - 1);
        m_phase = (m_phase + 1) % TICK_DIV;
        if (tick && !m_fresh && !chain_zero) cnt = 1;
        if (!door_closed || stop_clr) ns = S_PAUSE;
        else if (!m_fresh && chain_zero) begin ns = S_DONE; m_phase = 0; m_beeps = 0; end
        m_fresh = 0;
      end
      S_PAUSE: begin
        if (door_closed && stop_clr) begin m_digits.delete(); ns = S_IDLE; end
        else if (door_closed && start) ns = S_RUN;
      end
      S_DONE: begin
        tick = (m_phase == TICK_DIV - 1);
        m_phase = (m_phase + 1) % TICK_DIV;
        if (door_closed && stop_clr) begin m_digits.delete(); ns = S_IDLE; end
        else if (tick) begin
          m_beeps++;
          if (m_beeps == BEEP_SECS) begin m_digits.delete(); ns = S_IDLE; end
        end
      end
      default: ns = S_IDLE;
    endcase
    m_state    = ns;
    cur.st     = 3'(ns);
    cur.entry  = 16'(entry_val());
    cur.load_n = !load;
    cur.cnt_en = cnt;
    cur.mag_on = (ns == S_RUN);
    cur.beep   = (ns == S_DONE);
    cur.err    = err;
    exp_q.push_back(cur);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_state", state, e.st);
        chk("sb_entry", entry, e.entry);
        chk("sb_load_n", load_n, e.load_n);
        chk("sb_cnt_en", cnt_en, e.cnt_en);
        chk("sb_mag_on", mag_on, e.mag_on);
        chk("sb_beep", beep, e.beep);
        chk("sb_entry_err", entry_err, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chain_zero = (m_chain == 0) || force_zero;
    key_valid = 1'b0;
    start = 1'b0;
    stop_clr = 1'b0;
  endtask

  task automatic press(int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    step();
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_entry"}, entry, 0);
    chk({tag, "_load_n"}, load_n, 1);
    chk({tag, "_cnt_en"}, cnt_en, 0);
    chk({tag, "_mag_on"}, mag_on, 0);
    chk({tag, "_beep"}, beep, 0);
    chk({tag, "_entry_err"}, entry_err, 0);
  endtask

  task automatic count_beep_to_idle(string tag);
    int b = beep ? 1 : 0;
    int i = 0;
    while (i < 40 && state != 3'd0) begin
      step();
      if (beep) b++;
      i++;
    end
    chk({tag, "_back_idle"}, state, 0);
    chk({tag, "_beep_cycles"}, b, 2 * TICK_DIV);
    chk({tag, "_entry_clear"}, entry, 0);
  endtask

  initial begin : stimulus
    int n;
    int r;
    m_chain = 0;
    force_zero = 0;
    model_reset();
    #12;
    chk_reset_values("reset");
    @(posedge clk); #1 clrn = 1'b1;

    // Invalid time 00:99 is rejected
    press(9); press(9);
    chk("e99_entry", entry, 16'h0099);
    start = 1'b1; step();
    chk("e99_err", entry_err, 1);
    chk("e99_state", state, S_SET);
    chk("e99_load_n", load_n, 1);
    stop_clr = 1'b1; step();
    chk("e99_clear", entry, 0);

    // 01:30, tick pacing, door pause and phase-preserving resume
    press(1); press(3); press(0);
    chk("e130_entry", entry, 16'h0130);
    start = 1'b1; step();
    chk("e130_load", load_n, 0);
    chk("e130_run", state, S_RUN);
    n = 0;
    for (int i = 0; i < 9; i++) begin step(); if (cnt_en) n++; if (!load_n) n += 100; end
    chk("e130_two_ticks", n, 2);
    door_closed = 1'b0; step();
    chk("door_pause", state, S_PAUSE);
    chk("door_mag_off", mag_on, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin step(); if (cnt_en) n++; end
    door_closed = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (cnt_en) n++; end
    chk("pause_no_tick", n, 0);
    start = 1'b1; step();
    chk("resume_run", state, S_RUN);
    chk("resume_no_load", load_n, 1);
    step();
    chk("resume_phase_a", cnt_en, 0);
    step();
    chk("resume_phase_b", cnt_en, 1);
    start = 1'b1; stop_clr = 1'b1; step();
    chk("start_stop_pause", state, S_PAUSE);
    stop_clr = 1'b1; step();
    chk("pause_clear_state", state, S_IDLE);
    chk("pause_clear_entry", entry, 0);

    // Forced chain_zero while running
    press(1); press(0); press(0);
    start = 1'b1; step();
    step(); step(); step();
    force_zero = 1; chain_zero = 1'b1;
    step();
    force_zero = 0;
    chk("force_done", state, S_DONE);
    chk("force_beep", beep, 1);
    chk("force_mag", mag_on, 0);
    count_beep_to_idle("force");

    // Natural countdown of five seconds through the chain model
    press(5);
    start = 1'b1; step();
    n = 0;
    for (int i = 0; i < 100 && state != 3'(S_DONE); i++) begin step(); if (cnt_en) n++; end
    chk("nat_done", state, S_DONE);
    chk("nat_ticks", n, 5);
    count_beep_to_idle("nat");

    // Reset in the middle of cooking, then five-key overflow
    press(2); press(0); press(0);
    start = 1'b1; step();
    for (int i = 0; i < 6; i++) step();
    chk("pre_reset_mag", mag_on, 1);
    @(negedge clk); #1 clrn = 1'b0;
    #1 chk_reset_values("midrun_reset");
    @(posedge clk); @(posedge clk); #1 clrn = 1'b1;
    model_reset();
    press(1); press(2); press(3); press(4); press(5);
    chk("five_keys", entry, 16'h2345);
    stop_clr = 1'b1; step();

    // Randomized operation checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      case (m_state)
        S_IDLE, S_SET: begin
          door_closed = 1'b1;
          if (r < 30) begin key_valid = 1'b1; key_digit = 4'($urandom_range(0, 11)); end
          else if (r < 45) start = 1'b1;
          else if (r < 49) stop_clr = 1'b1;
        end
        S_RUN: begin
          door_closed = 1'b1;
          if (!(chain_zero && !m_fresh)) begin
            if (r < 2) door_closed = 1'b0;
            else if (r < 4) stop_clr = 1'b1;
            else if (r < 5) begin start = 1'b1; stop_clr = 1'b1; end
          end
          if (r >= 90) start = 1'b1;
        end
        S_PAUSE: begin
          door_closed = ($urandom_range(0, 3) != 0);
          if (r < 20) start = 1'b1;
          else if (r < 26 && door_closed) stop_clr = 1'b1;
        end
        default: begin
          door_closed = 1'b1;
          if (r < 3) stop_clr = 1'b1;
        end
      endcase
      step();
    end

    door_closed = 1'b1;
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
